// File: rtl/prog_truth_table_lut.sv
// ---------------------------------------------------------------------------
// prog_truth_table_lut
//
// Run-time reprogrammable N-input truth-table evaluator. The active truth
// table lives in a register. A serial config port fills a shadow buffer, and
// the buffer is copied into the active table in one atomic commit cycle.
// Evaluation is a single-stage valid/ready pipeline that is never stalled by
// configuration activity.
//
// Table convention: row index idx = in_bits (unsigned), and the result is
// tt_active[TT_W-1-idx]. The MSB of the hex constant is therefore the
// all-zeros row. For example, 8'hB6 gives rows 000..111 = 1,0,1,1,0,1,1,0.
//
// Parameters:
//   N_INPUTS     number of logic inputs (1..6); TT_W = 2**N_INPUTS
//   TT_RESET     truth table loaded at reset (TT_W bits)
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     input vector valid
//   in_ready     block can accept a vector
//   in_bits      logic inputs, in_bits[N_INPUTS-1] is the first input (MSB)
//   out_valid    out holds a result
//   out_ready    downstream accepts the result
//   out          evaluated logic value
//   cfg_start    begin a table reload (pulse, honoured only when idle)
//   cfg_abort    cancel a reload in progress
//   cfg_valid    cfg_bit valid
//   cfg_ready    config port is accepting bits
//   cfg_bit      serial table bit; the first bit sent is row 0
//   cfg_busy     reload in progress (LOAD or COMMIT)
//   cfg_done     one-cycle pulse while the new table is being committed
//
// Optional build macro TT_READBACK_EN adds:
//   tt_readback  copy of the registered active table
//   commit_count 8-bit wrapping count of commits
// ---------------------------------------------------------------------------
module prog_truth_table_lut #(
    parameter int                       N_INPUTS = 3,
    parameter logic [(2**N_INPUTS)-1:0] TT_RESET = 8'hB6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_INPUTS-1:0]         in_bits,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out,
    input  logic                        cfg_start,
    input  logic                        cfg_abort,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic                        cfg_bit,
    output logic                        cfg_busy,
`ifdef TT_READBACK_EN
    output logic                        cfg_done,
    output logic [(2**N_INPUTS)-1:0]    tt_readback,
    output logic [7:0]                  commit_count
`else
    output logic                        cfg_done
`endif
);

    localparam int TT_W  = 2**N_INPUTS;
    // One extra bit so the counter can represent TT_W itself without wrapping.
    localparam int CNT_W = $clog2(TT_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } cfg_state_t;

    cfg_state_t        state;
    cfg_state_t        state_next;

    logic [TT_W-1:0]   tt_active;
    logic [TT_W-1:0]   tt_rows;
    logic [TT_W-1:0]   shadow;
    logic [CNT_W-1:0]  bit_cnt;

    logic              cfg_xfer;
    logic              last_bit;
    logic              eval_accept;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------

    // Abort wins over a transfer in the same cycle, so that bit is dropped.
    assign cfg_xfer    = cfg_valid && cfg_ready && !cfg_abort;
    assign last_bit    = (bit_cnt == CNT_W'(TT_W - 1));

    assign in_ready    = !out_valid || out_ready;
    assign eval_accept = in_valid && in_ready;

    // Reorder the table so that row r sits at bit r. This lets in_bits index
    // the table directly, with no subtraction.
    for (genvar r = 0; r < TT_W; r++) begin : g_rows
        assign tt_rows[r] = tt_active[TT_W-1-r];
    end

    // ------------------------------------------------------------------
    // Config FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Config FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    state_next = IDLE;
                end else if (cfg_xfer && last_bit) begin
                    state_next = COMMIT;
                end
            end
            // COMMIT always lasts exactly one cycle. Abort is not looked at.
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Config FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready = 1'b0;
        cfg_busy  = 1'b0;
        cfg_done  = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_ready = 1'b0;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                cfg_busy  = 1'b1;
            end
            COMMIT: begin
                cfg_busy  = 1'b1;
                cfg_done  = 1'b1;
            end
            default: begin
                cfg_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow buffer and bit counter
    // ------------------------------------------------------------------

    // Bits shift in at the LSB, so after TT_W transfers the first bit sent
    // (row 0) ends up in the MSB. That matches the table convention. The
    // counter restarts on every new load.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE && cfg_start) begin
            bit_cnt <= '0;
        end else if (cfg_xfer) begin
            shadow  <= {shadow[TT_W-2:0], cfg_bit};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Active truth table
    // ------------------------------------------------------------------

    // The new table becomes visible at the edge that closes COMMIT. An
    // evaluation accepted during COMMIT still reads the old table.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_active <= TT_RESET;
        end else if (state == COMMIT) begin
            tt_active <= shadow;
        end
    end

    // ------------------------------------------------------------------
    // Evaluation pipeline stage
    // ------------------------------------------------------------------

    // A new accept always loads the stage. Otherwise a completed handshake
    // empties it. While downstream stalls, out and out_valid hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= 1'b0;
        end else if (eval_accept) begin
            out_valid <= 1'b1;
            out       <= tt_rows[in_bits];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef TT_READBACK_EN
    // ------------------------------------------------------------------
    // Readback and commit counter
    // ------------------------------------------------------------------
    assign tt_readback = tt_active;

    // Counts committed reloads. It wraps naturally from 255 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_count <= 8'd0;
        end else if (state == COMMIT) begin
            commit_count <= commit_count + 8'd1;
        end
    end
`endif

endmodule
